// File: rtl/stdout_slave_if.sv
// Peripheral bus between a core-side master and the stdout slave.
// One request/grant phase and a single-cycle response phase.
interface stdout_slave_if #(
    parameter int IdWidth = 5
);
    logic               req_i;
    logic [31:0]        add_i;
    logic               wen_i;
    logic [31:0]        wdata_i;
    logic [3:0]         be_i;
    logic [IdWidth-1:0] id_i;
    logic               gnt_o;
    logic               r_valid_o;
    logic [31:0]        r_rdata_o;
    logic               r_opc_o;
    logic [IdWidth-1:0] r_id_o;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i, id_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o, r_id_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i, id_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o, r_id_o
    );
endinterface

// File: rtl/stdout_slave.sv
// Stdout slave: collects per-core characters from bus writes into a shared
// first-word-fall-through FIFO and streams them out tagged with core index.
module stdout_slave #(
    parameter int NumCores  = 8,
    parameter int FifoDepth = 16,
    parameter int IdWidth   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  cluster_id_i,
    stdout_slave_if.slave bus,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic [3:0]  tx_core_o,
    output logic [5:0]  tx_cluster_o
);
    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;

    logic [11:0]        mem [FifoDepth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      fill;
    logic               full;
    logic               empty;
    logic               gnt;
    logic               push;
    logic               pop;
    logic [11:0]        offset;
    logic [3:0]         core;
    logic               in_window;
    logic               core_ok;
    logic               wr_push;
    logic               wr_err;
    logic [31:0]        rd_val;
    logic [11:0]        head;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_opc;
    logic [IdWidth-1:0] rsp_id;
    logic               unused_bits;

    assign offset    = bus.add_i[11:0];
    assign in_window = ~offset[11];
    assign core      = offset[6:3];
    assign core_ok   = {1'b0, core} < 5'(NumCores);

    assign full  = (fill == CW'(FifoDepth));
    assign empty = (fill == '0);

    // Grant depends only on fullness, never on a same-cycle pop, so the
    // bus handshake has no combinational path from the stream consumer.
    assign gnt  = bus.req_i & ~full & ~rst_i;
    assign push = gnt & wr_push;
    assign pop  = ~empty & tx_ready_i;

    // Decode the request into push/error/read-data; core range errors take
    // priority over a disabled byte lane.
    always_comb begin
        wr_push = 1'b0;
        wr_err  = 1'b0;
        rd_val  = '0;
        if (!bus.wen_i) begin
            if (in_window) begin
                if (!core_ok) wr_err  = 1'b1;
                else          wr_push = bus.be_i[0];
            end else begin
                wr_err = 1'b1;
            end
        end else if (offset == 12'h800) begin
            rd_val = 32'(fill);
        end else if (offset == 12'h804) begin
            rd_val = 32'(FifoDepth);
        end
    end

    // Response register: one cycle after each grant, all zero otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_opc   <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= gnt;
            rsp_rdata <= gnt ? rd_val : '0;
            rsp_opc   <= gnt & wr_err;
            rsp_id    <= gnt ? bus.id_i : '0;
        end
    end

    // FIFO pointers and fill count; pointers wrap naturally at FifoDepth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Character storage; contents are irrelevant while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {core, bus.wdata_i[7:0]};
    end

    assign head         = mem[rd_ptr];
    assign tx_valid_o   = ~empty;
    assign tx_data_o    = empty ? 8'h00 : head[7:0];
    assign tx_core_o    = empty ? 4'h0  : head[11:8];
    assign tx_cluster_o = cluster_id_i;

    assign bus.gnt_o     = gnt;
    assign bus.r_valid_o = rsp_valid;
    assign bus.r_rdata_o = rsp_rdata;
    assign bus.r_opc_o   = rsp_opc;
    assign bus.r_id_o    = rsp_id;

    assign unused_bits = ^{bus.add_i[31:12], bus.wdata_i[31:8], bus.be_i[3:1]};
endmodule

// File: tb/tb_stdout_slave.sv
// Self-checking bench for stdout_slave: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_stdout_slave;
    localparam int NCORES = 8;
    localparam int DEPTH  = 16;
    localparam int IDW    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cluster = 6'h2a;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [3:0] tx_core;
    logic [5:0] tx_cluster;

    stdout_slave_if #(.IdWidth(IDW)) bus_if ();

    stdout_slave #(
        .NumCores (NCORES),
        .FifoDepth(DEPTH),
        .IdWidth  (IDW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cluster_id_i(cluster),
        .bus         (bus_if),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .tx_data_o   (tx_data),
        .tx_core_o   (tx_core),
        .tx_cluster_o(tx_cluster)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the FIFO is just an ordered list of {core, char}.
    logic [11:0] q[$];

    logic           obs_gnt, obs_txv, obs_rv, obs_opc;
    logic [7:0]     obs_txd;
    logic [3:0]     obs_txc;
    logic [5:0]     obs_cl;
    logic [31:0]    obs_rdata;
    logic [IDW-1:0] obs_rid;
    logic           exp_gnt, exp_txv, exp_rv, exp_opc;
    logic [7:0]     exp_txd;
    logic [3:0]     exp_txc;
    logic [31:0]    exp_rdata;
    logic [IDW-1:0] exp_rid;

    // One bus cycle: drive, sample pre-edge outputs at the falling edge,
    // sample the response after the rising edge, then advance the model.
    task automatic step(input bit req, input logic [31:0] addr, input bit wen,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [IDW-1:0] id, input bit ready);
        bit          do_push;
        logic [11:0] off;
        bus_if.req_i   = req;
        bus_if.add_i   = addr;
        bus_if.wen_i   = wen;
        bus_if.wdata_i = wdata;
        bus_if.be_i    = be;
        bus_if.id_i    = id;
        tx_ready       = ready;
        @(negedge clk);
        obs_gnt = bus_if.gnt_o;
        obs_txv = tx_valid;
        obs_txd = tx_data;
        obs_txc = tx_core;
        obs_cl  = tx_cluster;
        exp_gnt = req && (q.size() < DEPTH);
        exp_txv = q.size() > 0;
        exp_txd = exp_txv ? q[0][7:0]  : 8'h00;
        exp_txc = exp_txv ? q[0][11:8] : 4'h0;
        exp_rv    = exp_gnt;
        exp_rid   = exp_gnt ? id : '0;
        exp_opc   = 1'b0;
        exp_rdata = '0;
        do_push   = 1'b0;
        off       = addr[11:0];
        if (exp_gnt) begin
            if (!wen) begin
                if (off < 12'h800) begin
                    if (int'(addr[6:3]) >= NCORES) exp_opc = 1'b1;
                    else if (be[0]) do_push = 1'b1;
                end else begin
                    exp_opc = 1'b1;
                end
            end else if (off == 12'h800) begin
                exp_rdata = q.size();
            end else if (off == 12'h804) begin
                exp_rdata = DEPTH;
            end
        end
        @(posedge clk);
        #1;
        obs_rv    = bus_if.r_valid_o;
        obs_opc   = bus_if.r_opc_o;
        obs_rdata = bus_if.r_rdata_o;
        obs_rid   = bus_if.r_id_o;
        if (exp_txv && ready) void'(q.pop_front());
        if (do_push) q.push_back({addr[6:3], wdata[7:0]});
    endtask

    task automatic idle(input bit ready);
        step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, '0, ready);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        q.delete();
        bus_if.req_i = 1'b1; bus_if.add_i = 32'h18; bus_if.wen_i = 1'b0;
        bus_if.wdata_i = 32'h41; bus_if.be_i = 4'hf; bus_if.id_i = 5'h3;
        tx_ready = 1'b1;
        #2;
        n_tests++;
        if ({bus_if.gnt_o, bus_if.r_valid_o, tx_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got gnt/rv/txv=%b expected 000",
                     {bus_if.gnt_o, bus_if.r_valid_o, tx_valid});
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus_if.r_rdata_o, bus_if.r_opc_o, bus_if.r_id_o, tx_data, tx_core, bus_if.gnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h opc=%b id=%h txd=%h txc=%h gnt=%b expected all 0",
                     bus_if.r_rdata_o, bus_if.r_opc_o, bus_if.r_id_o, tx_data, tx_core, bus_if.gnt_o);
        end
        bus_if.req_i = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_write;
        step(1'b1, 32'h018, 1'b0, 32'h41, 4'hf, 5'd7, 1'b1);
        n_tests++;
        if (obs_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gnt: got %b expected 1", obs_gnt);
        end
        n_tests++;
        if ({obs_rv, obs_opc, obs_rdata, obs_rid} !== {1'b1, 1'b0, 32'h0, 5'd7}) begin
            n_fail++;
            $display("FAIL single_rsp: got rv=%b opc=%b rdata=%h id=%h expected 1 0 0 07",
                     obs_rv, obs_opc, obs_rdata, obs_rid);
        end
        idle(1'b1);
        n_tests++;
        if ({obs_txv, obs_txd, obs_txc, obs_cl} !== {1'b1, 8'h41, 4'd3, 6'h2a}) begin
            n_fail++;
            $display("FAIL single_tx: got v=%b d=%h c=%h cl=%h expected 1 41 3 2a",
                     obs_txv, obs_txd, obs_txc, obs_cl);
        end
        n_tests++;
        if (obs_rv !== 1'b0) begin
            n_fail++;
            $display("FAIL single_one_rsp: got rv=%b expected 0", obs_rv);
        end
    endtask

    task automatic test_errors;
        step(1'b1, 32'h078, 1'b0, 32'h55, 4'hf, 5'd1, 1'b1);
        n_tests++;
        if ({obs_gnt, obs_rv, obs_opc} !== 3'b111) begin
            n_fail++;
            $display("FAIL err_core: got gnt/rv/opc=%b expected 111", {obs_gnt, obs_rv, obs_opc});
        end
        step(1'b1, 32'h800, 1'b0, 32'h56, 4'hf, 5'd2, 1'b1);
        n_tests++;
        if ({obs_rv, obs_opc} !== 2'b11) begin
            n_fail++;
            $display("FAIL err_high: got rv/opc=%b expected 11", {obs_rv, obs_opc});
        end
        step(1'b1, 32'h804, 1'b1, 32'h0, 4'hf, 5'd3, 1'b1);
        n_tests++;
        if ({obs_rv, obs_opc, obs_rdata, obs_rid} !== {1'b1, 1'b0, 32'd16, 5'd3}) begin
            n_fail++;
            $display("FAIL rd_capacity: got rv=%b opc=%b rdata=%h id=%h expected 1 0 10 03",
                     obs_rv, obs_opc, obs_rdata, obs_rid);
        end
        step(1'b1, 32'h100, 1'b1, 32'h0, 4'hf, 5'd4, 1'b1);
        n_tests++;
        if ({obs_rv, obs_opc, obs_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rd_other: got rv=%b opc=%b rdata=%h expected 1 0 0",
                     obs_rv, obs_opc, obs_rdata);
        end
        step(1'b1, 32'h010, 1'b0, 32'h57, 4'he, 5'd5, 1'b1);
        n_tests++;
        if ({obs_rv, obs_opc} !== 2'b10) begin
            n_fail++;
            $display("FAIL be_off: got rv/opc=%b expected 10", {obs_rv, obs_opc});
        end
        idle(1'b1);
        n_tests++;
        if (obs_txv !== 1'b0) begin
            n_fail++;
            $display("FAIL err_nopush: got tx_valid=%b expected 0", obs_txv);
        end
    endtask

    task automatic test_fill_drain;
        logic [7:0] seen[$];
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 32'(((i % NCORES) << 3)), 1'b0, 32'(8'h30 + i), 4'h1, 5'(i), 1'b0);
            n_tests++;
            if (obs_gnt !== (i < 16)) begin
                n_fail++;
                $display("FAIL fill_gnt[%0d]: got %b expected %b", i, obs_gnt, (i < 16));
            end
        end
        step(1'b1, 32'h800, 1'b1, 32'h0, 4'hf, 5'd9, 1'b0);
        n_tests++;
        if (obs_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL full_status_gnt: got %b expected 0", obs_gnt);
        end
        step(1'b1, 32'(((16 % NCORES) << 3)), 1'b0, 32'h40, 4'h1, 5'd16, 1'b1);
        n_tests++;
        if (obs_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_no_gnt: got %b expected 0", obs_gnt);
        end
        if (obs_txv) seen.push_back(obs_txd);
        step(1'b1, 32'(((16 % NCORES) << 3)), 1'b0, 32'h40, 4'h1, 5'd16, 1'b1);
        n_tests++;
        if (obs_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_gnt: got %b expected 1", obs_gnt);
        end
        if (obs_txv) seen.push_back(obs_txd);
        for (int i = 0; i < 24; i++) begin
            idle(1'b1);
            if (obs_txv) seen.push_back(obs_txd);
        end
        n_tests++;
        if (seen.size() != 17) begin
            n_fail++;
            $display("FAIL drain_count: got %0d expected 17", seen.size());
        end
        for (int i = 0; i < 17 && i < seen.size(); i++) begin
            n_tests++;
            if (seen[i] !== 8'(8'h30 + i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got %h expected %h", i, seen[i], 8'(8'h30 + i));
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'(i << 3), 1'b0, 32'(8'h60 + i), 4'h1, 5'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'(((i + 5) % NCORES) << 3), 1'b0, 32'(8'h65 + i), 4'h1, 5'(i), 1'b1);
            n_tests++;
            if ({obs_gnt, obs_txv, obs_txd, obs_txc} !== {exp_gnt, exp_txv, exp_txd, exp_txc}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got gnt=%b v=%b d=%h c=%h expected %b %b %h %h", i,
                         obs_gnt, obs_txv, obs_txd, obs_txc, exp_gnt, exp_txv, exp_txd, exp_txc);
            end
        end
        step(1'b1, 32'h800, 1'b1, 32'h0, 4'hf, 5'd1, 1'b0);
        n_tests++;
        if (obs_rdata !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_status: got %0d expected 5", obs_rdata);
        end
    endtask

    task automatic test_random;
        logic [31:0] addr;
        bit          wen, ready;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            sel  = $urandom_range(0, 9);
            addr = $urandom;
            wen  = $urandom_range(0, 3) == 0;
            if (sel <= 5) begin
                addr[11] = 1'b0;
            end else if (sel == 6) begin
                addr[11:0] = 12'h800; wen = 1'b1;
            end else if (sel == 7) begin
                addr[11:0] = 12'h804; wen = 1'b1;
            end
            ready = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 3) != 0, addr, wen, $urandom, 4'($urandom), 5'($urandom), ready);
            n_tests++;
            if ({obs_gnt, obs_rv, obs_opc, obs_rdata, obs_rid} !== {exp_gnt, exp_rv, exp_opc, exp_rdata, exp_rid}) begin
                n_fail++;
                $display("FAIL rnd_bus[%0d]: got gnt=%b rv=%b opc=%b rdata=%h id=%h expected %b %b %b %h %h", i,
                         obs_gnt, obs_rv, obs_opc, obs_rdata, obs_rid, exp_gnt, exp_rv, exp_opc, exp_rdata, exp_rid);
            end
            n_tests++;
            if (obs_txv !== exp_txv || (exp_txv && {obs_txd, obs_txc} !== {exp_txd, exp_txc})) begin
                n_fail++;
                $display("FAIL rnd_tx[%0d]: got v=%b d=%h c=%h expected %b %h %h", i,
                         obs_txv, obs_txd, obs_txc, exp_txv, exp_txd, exp_txc);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 40 && q.size() > 0; i++) idle(1'b1);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pre_drain: got %0d entries expected 0", q.size());
        end
        for (int i = 0; i < 7; i++)
            step(1'b1, 32'(i << 3), 1'b0, 32'(8'h70 + i), 4'h1, 5'(i), 1'b0);
        step(1'b1, 32'h800, 1'b1, 32'h0, 4'hf, 5'd12, 1'b0);
        n_tests++;
        if ({obs_rv, obs_rdata} !== {1'b1, 32'd7}) begin
            n_fail++;
            $display("FAIL pre_rst_status: got rv=%b rdata=%0d expected 1 7", obs_rv, obs_rdata);
        end
        bus_if.req_i = 1'b1;
        rst = 1'b1;
        q.delete();
        #1;
        n_tests++;
        if ({bus_if.r_valid_o, tx_valid, bus_if.gnt_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_rst: got rv/txv/gnt=%b expected 000",
                     {bus_if.r_valid_o, tx_valid, bus_if.gnt_o});
        end
        @(negedge clk);
        bus_if.req_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 32'h800, 1'b1, 32'h0, 4'hf, 5'd13, 1'b0);
        n_tests++;
        if ({obs_gnt, obs_rv, obs_rdata, obs_txv} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_rst_status: got gnt=%b rv=%b rdata=%0d txv=%b expected 1 1 0 0",
                     obs_gnt, obs_rv, obs_rdata, obs_txv);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_errors();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
